// File: rtl/data_memory.sv
// data_memory: single-outstanding load/store responder in front of a
// word-organised RAM. A request is accepted in IDLE, waits LATENCY cycles,
// performs the RAM access on the edge entering RESP, then pulses o_rvalid.
// Optional build macro: DMEM_MISALIGN_FAULT_EN (misaligned half/word accesses
// are suppressed and flagged on o_fault instead of being silently aligned).
module data_memory #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_memsize,
  output logic        o_ready,
  output logic        o_rvalid,
  output logic [31:0] o_rdata,
  output logic        o_fault
);

  localparam int AW = $clog2(DEPTH);
  // Count value on which WAIT hands over to RESP.
  localparam logic [3:0] LAST_CNT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          do_access;
  logic          acc_write;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [1:0]    acc_size;
  logic [AW-1:0] acc_idx;
  logic          misaligned;
  logic [3:0]    byte_en;
  logic [31:0]   wlanes;
  logic [31:0]   rd_word;
  logic [31:0]   load_val;

  assign accept = i_req && (state_q == ST_IDLE);

  // Access operands: live inputs for a zero-latency access, latched copy otherwise.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_write = i_write;
      acc_addr  = i_addr;
      acc_wdata = i_wdata;
      acc_size  = i_memsize;
    end else begin
      acc_write = write_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_size  = size_q;
    end
  end

  assign acc_idx = acc_addr[AW+1:2];
  assign rd_word = mem[acc_idx];

`ifdef DMEM_MISALIGN_FAULT_EN
  assign misaligned = ((acc_size == SZ_HALF) && acc_addr[0]) ||
                      ((acc_size == SZ_WORD) && (acc_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Byte-lane enables, replicated store data and right-aligned load data.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    byte_en  = 4'b0000;
    wlanes   = '0;
    load_val = '0;
    unique case (acc_size)
      SZ_BYTE: begin
        byte_en  = 4'b0001 << acc_addr[1:0];
        wlanes   = {4{acc_wdata[7:0]}};
        load_val = {24'b0, rd_word[8*acc_addr[1:0] +: 8]};
      end
      SZ_HALF: begin
        byte_en  = acc_addr[1] ? 4'b1100 : 4'b0011;
        wlanes   = {2{acc_wdata[15:0]}};
        load_val = {16'b0, (acc_addr[1] ? rd_word[31:16] : rd_word[15:0])};
      end
      SZ_WORD: begin
        byte_en  = 4'b1111;
        wlanes   = acc_wdata;
        load_val = rd_word;
      end
      default: ;
    endcase
  end

  // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE, access on the edge into RESP.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    do_access = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write_d = i_write;
          addr_d  = i_addr;
          wdata_d = i_wdata;
          size_d  = i_memsize;
          cnt_d   = 4'd0;
          if (LATENCY == 0) begin
            state_d   = ST_RESP;
            do_access = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == LAST_CNT) begin
          state_d   = ST_RESP;
          cnt_d     = 4'd0;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (do_access) begin
      rdata_d = (acc_write || misaligned) ? 32'd0 : load_val;
      fault_d = misaligned;
    end
  end

  // Control and response registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= 2'b00;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // RAM write port: only the enabled lanes of the addressed word change.
  // NOTE: the RAM array has no reset; contents survive i_rst_n and map onto a plain RAM.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && do_access && acc_write && !misaligned) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[acc_idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  assign o_ready  = (state_q == ST_IDLE);
  assign o_rvalid = (state_q == ST_RESP);
  assign o_rdata  = rdata_q;
  assign o_fault  = fault_q;

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed vector table, byte-level reference model with
// randomized traffic, reset-during-wait and back-to-back throughput sequences.
module tb_data_memory;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;
  localparam int WIN     = 64;   // bytes of RAM covered by the random model

`ifdef DMEM_MISALIGN_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic        i_write = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic [1:0]  i_memsize = 2'b00;
  logic        o_ready;
  logic        o_rvalid;
  logic [31:0] o_rdata;
  logic        o_fault;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] model_bytes [WIN];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] exp_rdata;
    logic        exp_fault;
  } vec_t;

  vec_t vecs [18];

  data_memory #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (i_req),
    .i_write   (i_write),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .i_memsize (i_memsize),
    .o_ready   (o_ready),
    .o_rvalid  (o_rvalid),
    .o_rdata   (o_rdata),
    .o_fault   (o_fault)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One full transaction; called and returns at a falling edge.
  task automatic do_txn(input string name, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size,
                        input logic [31:0] exp_rdata, input logic exp_fault);
    int n;
    int got;
    n = 0;
    while (!o_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    check({name, ".ready"}, {31'b0, o_ready}, 32'd1);
    i_req = 1'b1; i_write = wr; i_addr = addr; i_wdata = wdata; i_memsize = size;
    @(posedge i_clk);
    #1 i_req = 1'b0;
    got = 0;
    for (int k = 1; k <= LATENCY + 6; k++) begin
      @(negedge i_clk);
      if (o_rvalid) begin
        got = k;
        break;
      end
    end
    check({name, ".latency"}, got, LATENCY + 1);
    check({name, ".rdata"}, o_rdata, exp_rdata);
    check({name, ".fault"}, {31'b0, o_fault}, {31'b0, exp_fault});
    @(negedge i_clk);
    check({name, ".pulse"}, {31'b0, o_rvalid}, 32'd0);
  endtask

  function automatic bit model_misaligned(input logic [31:0] addr, input logic [1:0] size);
    if (!FAULT_EN) return 1'b0;
    return (size == 2'b10 && addr[0]) || (size == 2'b11 && addr[1:0] != 2'b00);
  endfunction

  // Byte-addressed reference: addresses fold modulo WIN, lanes chosen by arithmetic.
  task automatic model_apply(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] size, output logic [31:0] rd, output logic flt);
    int a;
    int base;
    int nbytes;
    a = int'(addr % WIN);
    flt = model_misaligned(addr, size);
    rd = 32'd0;
    nbytes = (size == 2'b01) ? 1 : (size == 2'b10) ? 2 : (size == 2'b11) ? 4 : 0;
    base = (nbytes == 0) ? a : a - (a % nbytes);
    if (nbytes != 0 && !flt) begin
      for (int b = 0; b < nbytes; b++) begin
        if (wr) model_bytes[base + b] = wdata[8*b +: 8];
        else    rd[8*b +: 8] = model_bytes[base + b];
      end
    end
  endtask

  initial begin
    logic [31:0] exp_rd;
    logic        exp_flt;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    int          acc_cyc [$];
    int          n_resp;
    int          prev_valid;

    vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 2'b11, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h10,   32'h0,        2'b11, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h11,   32'h55,       2'b01, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h10,   32'h0,        2'b11, 32'hDEAD55EF, 1'b0};
    vecs[4]  = '{1'b0, 32'h13,   32'h0,        2'b01, 32'h000000DE, 1'b0};
    vecs[5]  = '{1'b0, 32'h12,   32'h0,        2'b10, 32'h0000DEAD, 1'b0};
    vecs[6]  = '{1'b0, 32'h10 + DEPTH*4, 32'h0, 2'b11, 32'hDEAD55EF, 1'b0};
    vecs[7]  = '{1'b0, 32'h11,   32'h0,        2'b01, 32'h00000055, 1'b0};
    vecs[8]  = '{1'b1, 32'h10,   32'hFFFFFFFF, 2'b00, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 32'h10,   32'h0,        2'b11, 32'hDEAD55EF, 1'b0};
    vecs[10] = '{1'b1, 32'h14,   32'h12345678, 2'b11, 32'h0, 1'b0};
    vecs[11] = '{1'b1, 32'h16,   32'hCAFEF00D, 2'b11, 32'h0, FAULT_EN};
    vecs[12] = '{1'b0, 32'h14,   32'h0,        2'b11,
                 FAULT_EN ? 32'h12345678 : 32'hCAFEF00D, 1'b0};
    vecs[13] = '{1'b0, 32'h11,   32'h0,        2'b10,
                 FAULT_EN ? 32'h0 : 32'h000055EF, FAULT_EN};
    vecs[14] = '{1'b0, 32'h16,   32'h0,        2'b10,
                 FAULT_EN ? 32'h00001234 : 32'h0000CAFE, 1'b0};
    vecs[15] = '{1'b1, 32'h12,   32'h0000BBAA, 2'b10, 32'h0, 1'b0};
    vecs[16] = '{1'b0, 32'h10,   32'h0,        2'b11, 32'hBBAA55EF, 1'b0};
    vecs[17] = '{1'b0, 32'h10,   32'h0,        2'b00, 32'h0, 1'b0};

    // Reset state.
    @(negedge i_clk);
    check("rst.ready",  {31'b0, o_ready},  32'd1);
    check("rst.rvalid", {31'b0, o_rvalid}, 32'd0);
    check("rst.rdata",  o_rdata,           32'd0);
    check("rst.fault",  {31'b0, o_fault},  32'd0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    check("idle.ready",  {31'b0, o_ready},  32'd1);
    check("idle.rvalid", {31'b0, o_rvalid}, 32'd0);
    check("idle.rdata",  o_rdata,           32'd0);

    // Directed vector table.
    foreach (vecs[i]) begin
      do_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
             vecs[i].size, vecs[i].exp_rdata, vecs[i].exp_fault);
    end

    // Give the modelled window known contents, then random traffic.
    for (int w = 0; w < WIN / 4; w++) begin
      wdata = $urandom();
      model_apply(1'b1, 32'(w * 4), wdata, 2'b11, exp_rd, exp_flt);
      do_txn($sformatf("init%0d", w), 1'b1, 32'(w * 4), wdata, 2'b11, exp_rd, exp_flt);
    end
    for (int t = 0; t < 60; t++) begin
      wr    = 1'($urandom_range(0, 1));
      addr  = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, WIN - 1));
      wdata = $urandom();
      size  = 2'($urandom_range(0, 3));
      model_apply(wr, addr, wdata, size, exp_rd, exp_flt);
      do_txn($sformatf("rnd%0d", t), wr, addr, wdata, size, exp_rd, exp_flt);
    end

    // Store accepted, reset pulsed during WAIT: store discarded, no response.
    model_apply(1'b0, 32'h20, 32'h0, 2'b11, exp_rd, exp_flt);
    i_req = 1'b1; i_write = 1'b1; i_addr = 32'h20; i_wdata = ~exp_rd; i_memsize = 2'b11;
    @(posedge i_clk);
    #1 i_req = 1'b0;
    @(negedge i_clk);
    check("rstw.in_wait", {31'b0, o_ready}, 32'd0);
    #1 i_rst_n = 1'b0;
    #1;
    check("rstw.rvalid_low", {31'b0, o_rvalid}, 32'd0);
    check("rstw.ready_in_rst", {31'b0, o_ready}, 32'd1);
    #2 i_rst_n = 1'b1;
    n_resp = 0;
    for (int k = 0; k < LATENCY + 4; k++) begin
      @(negedge i_clk);
      if (o_rvalid) n_resp++;
    end
    check("rstw.no_resp", n_resp, 0);
    check("rstw.ready_after", {31'b0, o_ready}, 32'd1);
    do_txn("rstw.readback", 1'b0, 32'h20, 32'h0, 2'b11, exp_rd, exp_flt);

    // Request held high: accepts exactly LATENCY+2 cycles apart.
    model_apply(1'b0, 32'h24, 32'h0, 2'b11, exp_rd, exp_flt);
    i_req = 1'b1; i_write = 1'b0; i_addr = 32'h24; i_memsize = 2'b11;
    n_resp = 0;
    prev_valid = 0;
    for (int c = 0; c < 24; c++) begin
      if (o_ready) acc_cyc.push_back(c);
      if (o_rvalid) begin
        n_resp++;
        check("tput.rdata", o_rdata, exp_rd);
        check("tput.pulse", prev_valid, 0);
      end
      prev_valid = int'(o_rvalid);
      @(negedge i_clk);
    end
    i_req = 1'b0;
    for (int k = 0; k < LATENCY + 3; k++) begin
      if (o_rvalid) n_resp++;
      @(negedge i_clk);
    end
    check("tput.accepts", acc_cyc.size(), 24 / (LATENCY + 2));
    check("tput.responses", n_resp, acc_cyc.size());
    for (int i = 1; i < acc_cyc.size(); i++) begin
      check($sformatf("tput.spacing%0d", i), acc_cyc[i] - acc_cyc[i-1], LATENCY + 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
